// File: rtl/sockit_spi_arb_pkg.sv
// Shared types and constants for the SPI command/data path arbiter.
package sockit_spi_arb_pkg;

    // Mux port numbering of the scw/sdw muxes and the sdr fork.
    typedef enum logic {
        ARB_XIP = 1'b0,
        ARB_REG = 1'b1
    } arb_port_t;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GNT_XIP = 2'd1;
    localparam logic [1:0] ARB_GNT_REG = 2'd2;
    localparam logic [1:0] ARB_DRAIN   = 2'd3;

endpackage

// File: rtl/sockit_spi_arb_if.sv
// Request/transfer inputs and grant outputs of the SPI path arbiter.
interface sockit_spi_arb_if #(
    parameter int RCW = 8
);
    logic           cfg_xen;
    logic           req_xip;
    logic           req_reg;
    logic           cmd_trn;
    logic           cmd_lst;
    logic [RCW-1:0] cmd_rdc;
    logic           sdr_trn;
    logic           sel;
    logic           ena;
    logic           bsy;
    logic           err;

    modport master (
        output cfg_xen, req_xip, req_reg, cmd_trn, cmd_lst, cmd_rdc, sdr_trn,
        input  sel, ena, bsy, err
    );

    modport slave (
        input  cfg_xen, req_xip, req_reg, cmd_trn, cmd_lst, cmd_rdc, sdr_trn,
        output sel, ena, bsy, err
    );
endinterface

// File: rtl/sockit_spi_arb_cnt.sv
// Saturating up/down counter of read words requested but not yet returned.
module sockit_spi_arb_cnt #(
    parameter int RCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RCW-1:0] add_i,
    input  logic           dec_i,
    output logic           zero_o,
    output logic           err_o
);

    logic [RCW-1:0] cnt_q;
    logic [RCW-1:0] cnt_d;
    logic [RCW:0]   sum;
    logic [RCW:0]   net;

    always_comb begin
        sum   = {1'b0, cnt_q} + {1'b0, add_i};
        net   = sum;
        cnt_d = sum[RCW-1:0];
        err_o = 1'b0;
        if (dec_i && (sum == '0)) begin
            // read word returned with nothing outstanding
            cnt_d = '0;
            err_o = 1'b1;
        end else begin
            net = sum - {{RCW{1'b0}}, dec_i};
            if (net[RCW]) begin
                cnt_d = '1;
                err_o = 1'b1;
            end else begin
                cnt_d = net[RCW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sockit_spi_arb.sv
// Transaction-level arbiter between the XIP port and the REG+DMA port; ownership
// moves only between SPI transactions once all outstanding read data is back.
module sockit_spi_arb
    import sockit_spi_arb_pkg::*;
#(
    parameter int RCW = 8,
    parameter int XTL = 2
) (
    input logic              clk,
    input logic              rst,
    sockit_spi_arb_if.slave  bus
);

    localparam int             XCW   = $clog2(XTL + 1);
    localparam logic [XCW-1:0] XTL_C = XCW'(XTL);

    arb_state_t     state_q, state_d;
    logic           sel_q, sel_d;
    logic [XCW-1:0] xcn_q, xcn_d;
    logic           err_q;
    logic           cnt_zero;
    logic           cnt_err;
    logic           end_trn;
    logic [RCW-1:0] add;

    assign end_trn = bus.cmd_trn && bus.cmd_lst;
    assign add     = bus.cmd_trn ? bus.cmd_rdc : '0;

    sockit_spi_arb_cnt #(
        .RCW (RCW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .add_i  (add),
        .dec_i  (bus.sdr_trn),
        .zero_o (cnt_zero),
        .err_o  (cnt_err)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        xcn_d   = xcn_q;
        case (state_q)
            ARB_IDLE: begin
                // XIP yields once it has used up its streak while REG waits
                if (bus.req_xip && bus.cfg_xen && !(bus.req_reg && (xcn_q == XTL_C))) begin
                    state_d = ARB_GNT_XIP;
                    sel_d   = ARB_XIP;
                end else if (bus.req_reg) begin
                    state_d = ARB_GNT_REG;
                    sel_d   = ARB_REG;
                    xcn_d   = '0;
                end
            end
            ARB_GNT_XIP: begin
                if (end_trn) begin
                    state_d = ARB_DRAIN;
                    if (bus.req_reg && (xcn_q != XTL_C)) begin
                        xcn_d = xcn_q + 1'b1;
                    end
                end
            end
            ARB_GNT_REG: begin
                if (end_trn) begin
                    state_d = ARB_DRAIN;
                end
            end
            default: begin
                if (cnt_zero) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= ARB_XIP;
            xcn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            xcn_q   <= xcn_d;
            err_q   <= err_q | cnt_err;
        end
    end

    assign bus.sel = sel_q;
    assign bus.ena = (state_q == ARB_GNT_XIP) || (state_q == ARB_GNT_REG);
    assign bus.bsy = (state_q != ARB_IDLE);
    assign bus.err = err_q;

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Self-checking bench for sockit_spi_arb: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_sockit_spi_arb;

    localparam int RCW = 8;
    localparam int XTL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // reference model: who owns the path, and how many read words are owed
    bit m_owned, m_drain, m_sel, m_err;
    int m_cnt, m_streak;

    sockit_spi_arb_if #(.RCW(RCW)) bus ();

    sockit_spi_arb #(.RCW(RCW), .XTL(XTL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // the datapath only moves command beats while the grant is open
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.cmd_trn === 1'b1 && bus.ena !== 1'b1) begin
            $display("FAIL cmd_trn_outside_grant ena=%b required 1", bus.ena);
            errors++;
        end
    end

    task automatic drv(input logic xen, input logic xip, input logic rg, input logic trn,
                       input logic lst, input logic [RCW-1:0] rdc, input logic sdr);
        bus.cfg_xen = xen;
        bus.req_xip = xip;
        bus.req_reg = rg;
        bus.cmd_trn = trn;
        bus.cmd_lst = lst;
        bus.cmd_rdc = rdc;
        bus.sdr_trn = sdr;
    endtask

    task automatic cycle();
        int n;
        @(posedge clk);
        if (rst) begin
            m_owned = 0; m_drain = 0; m_sel = 0; m_err = 0; m_cnt = 0; m_streak = 0;
        end else begin
            n = m_cnt + (bus.cmd_trn ? int'(bus.cmd_rdc) : 0) - (bus.sdr_trn ? 1 : 0);
            if (m_owned) begin
                if (bus.cmd_trn && bus.cmd_lst) begin
                    if (!m_sel && bus.req_reg && m_streak < XTL) m_streak++;
                    m_owned = 0;
                    m_drain = 1;
                end
            end else if (m_drain) begin
                if (m_cnt == 0) m_drain = 0;
            end else if (bus.req_xip && bus.cfg_xen && !(bus.req_reg && m_streak == XTL)) begin
                m_owned = 1; m_sel = 0;
            end else if (bus.req_reg) begin
                m_owned = 1; m_sel = 1; m_streak = 0;
            end
            if (n < 0) begin
                m_err = 1; n = 0;
            end else if (n > (1 << RCW) - 1) begin
                m_err = 1; n = (1 << RCW) - 1;
            end
            m_cnt = n;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                RCW'($urandom), 1'($urandom));
            cycle();
        end
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b0000) begin
            $display("FAIL reset sel/ena/bsy/err=%b required 0000", got); errors++;
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, '0, 0);
        cycle();
    endtask

    task automatic test_reg_only();
        logic [3:0] got;
        drv(0, 0, 1, 0, 0, '0, 0);
        cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1110) begin
            $display("FAIL reg_grant sel/ena/bsy/err=%b required 1110", got); errors++;
        end
        drv(0, 0, 0, 1, 0, '0, 0); cycle();
        drv(0, 0, 0, 1, 0, '0, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1110) begin
            $display("FAIL reg_hold sel/ena/bsy/err=%b required 1110", got); errors++;
        end
        drv(0, 0, 0, 1, 1, 8'd2, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1010) begin
            $display("FAIL reg_drain sel/ena/bsy/err=%b required 1010", got); errors++;
        end
        drv(0, 0, 0, 0, 0, '0, 1); cycle(); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1010) begin
            $display("FAIL reg_drain_last sel/ena/bsy/err=%b required 1010", got); errors++;
        end
        drv(0, 0, 0, 0, 0, '0, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1000) begin
            $display("FAIL reg_idle sel/ena/bsy/err=%b required 1000", got); errors++;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] got;
        logic       es;
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 3; g++) begin
                es = (g == 2);
                drv(1, 1, 1, 0, 0, '0, 0); cycle();
                got = {bus.sel, bus.ena, bus.bsy, bus.err};
                checks++;
                if (got !== {es, 3'b110}) begin
                    $display("FAIL fair_grant r%0d g%0d sel/ena/bsy/err=%b required %b",
                             r, g, got, {es, 3'b110}); errors++;
                end
                drv(1, 1, 1, 1, 1, '0, 0); cycle();
                got = {bus.sel, bus.ena, bus.bsy, bus.err};
                checks++;
                if (got !== {es, 3'b010}) begin
                    $display("FAIL fair_drain r%0d g%0d sel/ena/bsy/err=%b required %b",
                             r, g, got, {es, 3'b010}); errors++;
                end
                drv(1, 1, 1, 0, 0, '0, 0); cycle();
            end
        end
        drv(0, 0, 0, 0, 0, '0, 0); cycle();
    endtask

    task automatic test_xen_off();
        logic [3:0] got;
        drv(0, 1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({bus.ena, bus.bsy} !== 2'b00) begin
                $display("FAIL xen_off c%0d ena/bsy=%b required 00", i, {bus.ena, bus.bsy});
                errors++;
            end
        end
        drv(0, 1, 1, 0, 0, '0, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1110) begin
            $display("FAIL xen_off_reg sel/ena/bsy/err=%b required 1110", got); errors++;
        end
        drv(0, 0, 0, 1, 1, '0, 0); cycle();
        drv(0, 0, 0, 0, 0, '0, 0); cycle();
    endtask

    task automatic test_cnt();
        logic [3:0] got;
        drv(0, 0, 1, 0, 0, '0, 0); cycle();
        drv(0, 0, 0, 1, 0, 8'd1, 0); cycle();
        drv(0, 0, 0, 1, 1, 8'd3, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, '0, 1); cycle();
            got = {bus.sel, bus.ena, bus.bsy, bus.err};
            checks++;
            if (got !== 4'b1010) begin
                $display("FAIL cnt_add_dec read%0d sel/ena/bsy/err=%b required 1010", i, got);
                errors++;
            end
        end
        drv(0, 0, 0, 0, 0, '0, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1000) begin
            $display("FAIL cnt_add_dec_idle sel/ena/bsy/err=%b required 1000", got); errors++;
        end
        drv(0, 0, 1, 0, 0, '0, 0); cycle();
        drv(0, 0, 0, 1, 0, 8'hFE, 0); cycle();
        drv(0, 0, 0, 1, 1, 8'hFF, 0); cycle();
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b1011) begin
            $display("FAIL cnt_overflow sel/ena/bsy/err=%b required 1011", got); errors++;
        end
        drv(0, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 255; i++) cycle();
        checks++;
        if ({bus.bsy, bus.err} !== 2'b11) begin
            $display("FAIL cnt_sat_drain bsy/err=%b required 11", {bus.bsy, bus.err}); errors++;
        end
        drv(0, 0, 0, 0, 0, '0, 0); cycle();
        checks++;
        if ({bus.bsy, bus.err} !== 2'b01) begin
            $display("FAIL cnt_sat_idle bsy/err=%b required 01", {bus.bsy, bus.err}); errors++;
        end
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
    endtask

    task automatic test_err_rst();
        logic [3:0] got;
        drv(0, 0, 0, 0, 0, '0, 1); cycle();
        drv(0, 0, 0, 0, 0, '0, 0);
        checks++;
        if ({bus.bsy, bus.err} !== 2'b01) begin
            $display("FAIL unexpected_read bsy/err=%b required 01", {bus.bsy, bus.err}); errors++;
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (bus.err !== 1'b1) begin
                $display("FAIL err_sticky c%0d err=%b required 1", i, bus.err); errors++;
            end
        end
        drv(1, 1, 0, 0, 0, '0, 0); cycle();
        drv(1, 0, 0, 1, 0, 8'd4, 0); cycle();
        drv(0, 0, 0, 0, 0, '0, 0);
        rst = 1'b1; cycle();
        rst = 1'b0;
        got = {bus.sel, bus.ena, bus.bsy, bus.err};
        checks++;
        if (got !== 4'b0000) begin
            $display("FAIL rst_mid_xip sel/ena/bsy/err=%b required 0000", got); errors++;
        end
        drv(0, 0, 0, 0, 0, '0, 1); cycle();
        drv(0, 0, 0, 0, 0, '0, 0);
        checks++;
        if ({bus.bsy, bus.err} !== 2'b01) begin
            $display("FAIL rst_clears_cnt bsy/err=%b required 01", {bus.bsy, bus.err}); errors++;
        end
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
    endtask

    task automatic test_random();
        logic [3:0] got, exp;
        logic       trn, sdr;
        int         shown = 0;
        for (int i = 0; i < 3000; i++) begin
            trn = m_owned && ($urandom_range(0, 2) != 0);
            sdr = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 199) == 0);
            drv(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), trn,
                ($urandom_range(0, 3) == 0), RCW'($urandom_range(0, 3)), sdr);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
            got = {bus.sel, bus.ena, bus.bsy, bus.err};
            exp = {m_sel, m_owned, m_owned | m_drain, m_err};
            checks++;
            if (got !== exp) begin
                errors++;
                if (shown < 20) begin
                    $display("FAIL random c%0d sel/ena/bsy/err=%b required %b", i, got, exp);
                    shown++;
                end
            end
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, '0, 0);
        cycle();
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, '0, 0);
        test_reset();
        test_reg_only();
        test_fairness();
        test_xen_off();
        test_cnt();
        test_err_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
